// File: rtl/fetch_queue_if.sv
// fetch_queue_if: handshake bundle around the fetch stage.
//   Instruction memory : imem_req_valid/addr out, imem_req_ready in,
//                        imem_resp_valid/data in (responses in request order).
//   Decode / hazard    : redirect_valid/pc and stall in.
//   F/D register       : instr_valid, instr, pc_plus4 out.
// modport master is the fetch_queue side; slave is the environment side
// (memory + decode + hazard unit).
interface fetch_queue_if;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc_plus4;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    input  redirect_valid, redirect_pc, stall,
    output instr_valid, instr, pc_plus4
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    output redirect_valid, redirect_pc, stall,
    input  instr_valid, instr, pc_plus4
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: MIPS fetch front end. Issues word fetches to instruction
// memory, buffers returned words in an in-order queue and presents the head
// (instruction + PC+4) to the F/D register. Decode redirects flush the queue
// and discard every response still in flight.
//
// Ports:
//   clk, reset  - clock; synchronous active-high reset
//   fq          - fetch_queue_if.master (imem req/resp, redirect, stall,
//                 head instruction outputs)
//   bubble_cnt, redirect_cnt - saturating perf counters, only present when
//                 FETCH_PERF_EN is defined
//
// Parameters: DEPTH (queue entries and credit limit, power of 2, >= 2),
//             RESET_PC (first fetch address).
module fetch_queue #(
  parameter int unsigned  DEPTH    = 4,
  parameter logic [31:0]  RESET_PC = 32'h0040_0000
) (
  input  logic          clk,
  input  logic          reset,
  fetch_queue_if.master fq
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]   bubble_cnt,
  output logic [31:0]   redirect_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pcPlus4;
  } entry_t;

  entry_t        entries  [DEPTH];
  logic [31:0]   addrFifo [DEPTH];   // address of each outstanding request
  logic [AW-1:0] qHead, qTail, aHead, aTail;
  logic [CW-1:0] count, outstanding, dropCnt, outstandingNxt;
  logic [CW:0]   inUse;
  logic [31:0]   fetchPc;
  logic          headValid, accept, respIn, redirect, push, pop;

  // Credit: queued + outstanding never exceeds DEPTH, so a response always
  // has a free slot and is never back-pressured.
  assign inUse     = {1'b0, count} + {1'b0, outstanding};
  assign headValid = (count != '0);
  assign redirect  = fq.redirect_valid;
  assign respIn    = fq.imem_resp_valid;

  assign fq.imem_req_valid = !reset && (inUse < (CW+1)'(DEPTH));
  assign fq.imem_req_addr  = fetchPc;
  assign accept            = fq.imem_req_valid && fq.imem_req_ready;

  // A redirect kills both the arriving response and the head pop.
  assign push = respIn && (dropCnt == '0) && !redirect;
  assign pop  = headValid && !fq.stall && !redirect;

  assign outstandingNxt = outstanding + CW'(accept) - CW'(respIn);

  assign fq.instr_valid = headValid;
  assign fq.instr       = headValid ? entries[qHead].instr   : 32'h0;
  assign fq.pc_plus4    = headValid ? entries[qHead].pcPlus4 : 32'h0;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetchPc     <= RESET_PC;
      qHead       <= '0;
      qTail       <= '0;
      count       <= '0;
      aHead       <= '0;
      aTail       <= '0;
      outstanding <= '0;
      dropCnt     <= '0;
    end else begin
      // The address FIFO tracks every outstanding request, stale or not,
      // so it stays aligned with the memory's response order.
      outstanding <= outstandingNxt;
      if (accept) aTail <= aTail + AW'(1);
      if (respIn) aHead <= aHead + AW'(1);

      if (redirect) begin
        fetchPc <= {fq.redirect_pc[31:2], 2'b00};
        qHead   <= '0;
        qTail   <= '0;
        count   <= '0;
        // Everything still in flight after this cycle is wrong-path,
        // including a request accepted this very cycle.
        dropCnt <= outstandingNxt;
      end else begin
        if (accept) fetchPc <= fetchPc + 32'd4;
        if (respIn && (dropCnt != '0)) dropCnt <= dropCnt - CW'(1);
        if (push) qTail <= qTail + AW'(1);
        if (pop)  qHead <= qHead + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // Storage arrays carry no reset; validity comes from the pointers.
  always_ff @(posedge clk) begin
    if (accept) addrFifo[aTail] <= fetchPc;
    if (push)   entries[qTail]  <= '{instr: fq.imem_resp_data,
                                     pcPlus4: addrFifo[aHead] + 32'd4};
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_cnt   <= '0;
      redirect_cnt <= '0;
    end else begin
      if (!headValid && !fq.stall && (bubble_cnt != '1))
        bubble_cnt <= bubble_cnt + 32'd1;
      if (redirect && (redirect_cnt != '1))
        redirect_cnt <= redirect_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0040_0000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_queue_if fq();

`ifdef FETCH_PERF_EN
  logic [31:0] bubbleCnt, redirectCnt;
  logic [31:0] mBubble, mRedir;
`endif

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk),
    .reset(reset),
    .fq(fq)
`ifdef FETCH_PERF_EN
    ,
    .bubble_cnt(bubbleCnt),
    .redirect_cnt(redirectCnt)
`endif
  );

  // Memory model entry doubles as the reference's view of in-flight
  // requests: 'stale' marks wrong-path requests whose data must vanish.
  typedef struct { logic [31:0] addr; int due; bit stale; } memReq_t;
  typedef struct { logic [31:0] instr; logic [31:0] pc4; } ent_t;

  memReq_t     memQ[$];
  ent_t        mQ[$];
  logic [31:0] mPc;
  int cyc, lastDue, tests, fails;
  int pStall, pRedir, pReady, latMin, latMax;
  bit forceStall, forceRedir;
  logic [31:0] forcePc;
  bit trackLat;
  int firstAcc, firstVal;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      if (fails <= 40) $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] instrOf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic bit chance(input int pct);
    return int'($urandom_range(99)) < pct;
  endfunction

  function automatic logic [31:0] pickPc();
    case ($urandom_range(3))
      0:       return 32'h0040_0100;
      1:       return 32'h0040_0200 | $urandom_range(3);
      2:       return 32'hFFFF_FFF0 | $urandom_range(15);
      default: return $urandom;
    endcase
  endfunction

  task automatic cycle(input bit rst);
    bit stallV, redirV, readyV, respV, expReq, accept, deliver, popV, hv;
    logic [31:0] rpc, oldPc;
    memReq_t r;
    int due;
    @(negedge clk);
    stallV = forceStall || chance(pStall);
    redirV = !rst && (forceRedir || chance(pRedir));
    rpc    = forceRedir ? forcePc : pickPc();
    readyV = chance(pReady);
    respV  = !rst && (memQ.size() > 0) && (memQ[0].due <= cyc);
    reset  = rst;
    fq.stall           = stallV;
    fq.redirect_valid  = redirV;
    fq.redirect_pc     = rpc;
    fq.imem_req_ready  = readyV;
    fq.imem_resp_valid = respV;
    fq.imem_resp_data  = respV ? instrOf(memQ[0].addr) : 32'hDEAD_BEEF;
    #1;
    expReq = !rst && ((mQ.size() + memQ.size()) < DEPTH);
    hv     = mQ.size() > 0;
    chk("reqValid", 32'(fq.imem_req_valid), 32'(expReq));
    if (!rst) chk("reqAddr", fq.imem_req_addr, mPc);
    chk("instrValid", 32'(fq.instr_valid), 32'(hv));
    chk("instr", fq.instr, hv ? mQ[0].instr : 32'h0);
    chk("pcPlus4", fq.pc_plus4, hv ? mQ[0].pc4 : 32'h0);
`ifdef FETCH_PERF_EN
    chk("bubbleCnt", bubbleCnt, mBubble);
    chk("redirectCnt", redirectCnt, mRedir);
`endif
    accept = expReq && readyV;
    if (trackLat && accept && firstAcc < 0) firstAcc = cyc;
    if (trackLat && fq.instr_valid && firstVal < 0) firstVal = cyc;

    @(posedge clk);
    if (rst) begin
      mQ.delete();
      memQ.delete();
      mPc = RESET_PC;
      lastDue = cyc;
`ifdef FETCH_PERF_EN
      mBubble = 0;
      mRedir  = 0;
`endif
    end else begin
`ifdef FETCH_PERF_EN
      if (!hv && !stallV && mBubble != 32'hFFFF_FFFF) mBubble++;
      if (redirV && mRedir != 32'hFFFF_FFFF) mRedir++;
`endif
      deliver = 1'b0;
      if (respV) begin
        r = memQ.pop_front();
        deliver = !r.stale && !redirV;
      end
      popV  = hv && !stallV && !redirV;
      oldPc = mPc;
      if (redirV) begin
        mQ.delete();
        foreach (memQ[i]) memQ[i].stale = 1'b1;
        mPc = {rpc[31:2], 2'b00};
      end else begin
        if (popV) mQ.delete(0);
        if (deliver) mQ.push_back('{instr: instrOf(r.addr), pc4: r.addr + 32'd4});
        if (accept) mPc = mPc + 32'd4;
      end
      if (accept) begin
        due = cyc + int'($urandom_range(latMax, latMin));
        if (due <= lastDue) due = lastDue + 1;
        lastDue = due;
        memQ.push_back('{addr: oldPc, due: due, stale: redirV});
      end
    end
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0);
  endtask

  initial begin
    tests = 0; fails = 0; cyc = 0; lastDue = 0;
    pStall = 0; pRedir = 0; pReady = 100; latMin = 1; latMax = 1;
    forceStall = 0; forceRedir = 0; forcePc = 32'h0;
    trackLat = 0; firstAcc = -1; firstVal = -1;
    mPc = RESET_PC;
`ifdef FETCH_PERF_EN
    mBubble = 0; mRedir = 0;
`endif
    reset = 1'b1;
    fq.stall = 1'b0; fq.redirect_valid = 1'b0; fq.redirect_pc = 32'h0;
    fq.imem_req_ready = 1'b1; fq.imem_resp_valid = 1'b0; fq.imem_resp_data = 32'h0;
    @(posedge clk);
    cycle(1'b1);
    cycle(1'b1);

    // Streaming with 1-cycle memory: first word 2 cycles after first accept.
    trackLat = 1;
    run(30);
    trackLat = 0;
    chk("firstLat", 32'(firstVal - firstAcc), 32'd2);

    // Stall held 3 cycles: queue fills to DEPTH, head frozen, then drains.
    forceStall = 1;
    run(3);
    forceStall = 0;
    run(10);

    // Redirect with 3-cycle latency, then a second redirect one cycle later.
    latMin = 3; latMax = 3;
    run(4);
    forceRedir = 1; forcePc = 32'h0040_0100;
    cycle(1'b0);
    forceRedir = 0;
    cycle(1'b0);
    forceRedir = 1; forcePc = 32'h0040_0200;
    cycle(1'b0);
    forceRedir = 0;
    run(15);

    // Random mix of stalls, redirects, back-pressure and latency.
    pStall = 25; pRedir = 8; pReady = 70; latMin = 1; latMax = 3;
    run(1500);

    // Reset mid-stream with entries queued.
    pStall = 0; pRedir = 0; pReady = 100; latMin = 1; latMax = 1;
    forceStall = 1;
    for (int i = 0; i < 20 && mQ.size() < 3; i++) cycle(1'b0);
    cycle(1'b1);
    forceStall = 0;
    run(10);

    // Redirect-heavy tail, including targets near the 32-bit wrap.
    pStall = 20; pRedir = 30; pReady = 80; latMin = 1; latMax = 3;
    run(500);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
